counter_value_tx: RTL and testbench



---
 rtl/counter_value_tx.sv | 201 ++++++++++++++++++++
 tb/tb_counter_value_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_value_tx.sv
`default_nettype none
// ============================================================================
// Module  : counter_value_tx
// Brief   : Watches an 8-bit counter value, queues every change in a small
//           FIFO and sends each queued value LSB-first as a UART-style 8N1
//           frame on a single idle-high serial line.
//           Optional macro COUNTER_VALUE_TX_PARITY_EN adds an even-parity bit
//           between the data bits and the stop bit.
// Revision: 1.0 - initial release
// ============================================================================
module counter_value_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_AW      = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   value,
    output logic               tx,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [BW-1:0]      BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0]      BIT_LAST  = IW'(WIDTH - 1);
    localparam logic [FIFO_AW:0]   FULL_CNT  = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Change detector and FIFO storage
    logic [WIDTH-1:0]   prev_value;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               overflow_q;

    // Transmitter state
    state_t             state, state_n;
    logic [BW-1:0]      baud, baud_n;
    logic [IW-1:0]      bit_idx, bit_idx_n;
    logic [WIDTH-1:0]   shreg, shreg_n;
    logic               parity_bit, parity_n;
    logic               tx_q, tx_n;

    logic push, pop, full, push_ok;

    // A frame can only start from IDLE, so a pop never meets an empty FIFO.
    assign push    = (value != prev_value);
    assign full    = (count == FULL_CNT);
    assign pop     = (state == S_IDLE) && (count != '0);
    assign push_ok = push && (!full || pop);

    // FIFO storage: written on every accepted change, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem[wr_ptr] <= value;
        end
    end

    // Change detection, FIFO pointers/level and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_value <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev_value <= value;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (!push_ok && pop) begin
                count <= count - 1'b1;
            end
            if (push && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Transmitter next-state: tx is computed one cycle ahead so it leaves a flop.
    always_comb begin
        state_n   = state;
        baud_n    = baud;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        parity_n  = parity_bit;
        tx_n      = tx_q;
        case (state)
            S_IDLE: begin
                tx_n = 1'b1;
                if (pop) begin
                    shreg_n   = mem[rd_ptr];
                    parity_n  = ^mem[rd_ptr];
                    baud_n    = '0;
                    bit_idx_n = '0;
                    tx_n      = 1'b0;
                    state_n   = S_START;
                end
            end
            S_START: begin
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    tx_n    = shreg[0];
                    state_n = S_DATA;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            S_DATA: begin
                if (baud == BAUD_LAST) begin
                    baud_n = '0;
                    if (bit_idx == BIT_LAST) begin
`ifdef COUNTER_VALUE_TX_PARITY_EN
                        tx_n    = parity_bit;
                        state_n = S_PARITY;
`else
                        tx_n    = 1'b1;
                        state_n = S_STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                        shreg_n   = shreg >> 1;
                        tx_n      = shreg_n[0];
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            S_PARITY: begin
                // Only reachable when the parity option is compiled in.
                tx_n = parity_bit;
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    tx_n    = 1'b1;
                    state_n = S_STOP;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            S_STOP: begin
                tx_n = 1'b1;
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    state_n = S_IDLE;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            default: begin
                tx_n    = 1'b1;
                baud_n  = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    // Transmitter state register; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            baud       <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state      <= state_n;
            baud       <= baud_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            parity_bit <= parity_n;
            tx_q       <= tx_n;
        end
    end

    assign tx         = tx_q;
    assign busy       = (state != S_IDLE);
    assign fifo_level = count;
    assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_value_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_counter_value_tx
// Brief   : Scoreboard bench for counter_value_tx. A transaction-level model
//           (queue of pending values plus "line free at edge N") predicts the
//           frames and per-cycle status; a monitor decodes the serial line.
// Revision: 1.0 - initial release
// ============================================================================
module tb_counter_value_tx;

    localparam int W     = 8;
    localparam int C     = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
`ifdef COUNTER_VALUE_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int F = (W + 2 + P) * C;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  value = '0;
    logic          tx;
    logic          busy;
    logic [AW:0]   fifo_level;
    logic          overflow;

    counter_value_tx #(.WIDTH(W), .CLKS_PER_BIT(C), .FIFO_AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int q_model[$];
    int exp_frames[$];
    int prev_m   = 0;
    int ovf_m    = 0;
    bit active   = 0;
    int last_pop = 0;
    int last_val = 0;
    int next_ok  = 0;
    int e        = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, e, $time);
        end
    endtask

    // Expected line level at offset o cycles after the frame's pop edge.
    function automatic int tx_at(input int o, input int v);
        logic [W-1:0] vv;
        int slot;
        vv   = v[W-1:0];
        slot = o / C;
        if (slot == 0) return 0;
        if (slot <= W) return int'(vv[slot-1]);
        if (P == 1 && slot == W + 1) return int'(^vv);
        return 1;
    endfunction

    // One clock: drive inputs, advance the model across the edge, check status.
    task automatic step(input bit rst, input int val);
        bit pop_m;
        int off;
        reset = rst;
        value = val[W-1:0];
        if (rst) begin
            q_model.delete();
            exp_frames.delete();
            prev_m  = 0;
            ovf_m   = 0;
            active  = 0;
            next_ok = e + 1;
        end else begin
            pop_m = (q_model.size() > 0) && (e >= next_ok);
            if (pop_m) begin
                last_val = q_model.pop_front();
                exp_frames.push_back(last_val);
                last_pop = e;
                active   = 1;
                next_ok  = e + F + 1;
            end
            if (val != prev_m) begin
                if (q_model.size() < DEPTH) q_model.push_back(val);
                else ovf_m = 1;
            end
            prev_m = val;
        end
        @(negedge clk);
        off = e - last_pop;
        check("fifo_level", int'(fifo_level), q_model.size());
        check("overflow", int'(overflow), ovf_m);
        if (active && off < F) begin
            check("busy", int'(busy), 1);
            check("tx_frame", int'(tx), tx_at(off, last_val));
        end else begin
            check("busy", int'(busy), 0);
            check("tx_idle", int'(tx), 1);
        end
        e++;
    endtask

    task automatic hold(input int n, input int val);
        for (int i = 0; i < n; i++) step(1'b0, val);
    endtask

    // Monitor: UART receiver sampling mid-bit, scoreboarding decoded frames.
    int           rx_off = 0;
    bit           rx_on  = 0;
    bit           rx_bad = 0;
    logic [W-1:0] rx_data = '0;
    initial begin
        int slot;
        int expv;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                rx_on = 0;
            end else begin
                if (rx_on) rx_off++;
                else if (tx == 1'b0) begin
                    rx_on = 1; rx_off = 0; rx_bad = 0;
                end
                if (rx_on && (rx_off % C) == C / 2) begin
                    slot = rx_off / C;
                    if (slot == 0) begin
                        if (tx !== 1'b0) rx_bad = 1;
                    end else if (slot <= W) begin
                        rx_data[slot-1] = tx;
                    end else if (P == 1 && slot == W + 1) begin
                        if (tx !== ^rx_data) rx_bad = 1;
                    end else begin
                        if (tx !== 1'b1) rx_bad = 1;
                        if (exp_frames.size() == 0) begin
                            check("unexpected_frame", int'(rx_data), -1);
                        end else begin
                            expv = exp_frames.pop_front();
                            check("frame_data", int'(rx_data), expv);
                            check("frame_format_ok", int'(rx_bad), 0);
                        end
                        rx_on = 0;
                    end
                end
            end
        end
    end

    initial begin
        int cur;
        int r;
        @(negedge clk);
        // Reset, then a quiet line with a constant zero value.
        for (int i = 0; i < 3; i++) step(1'b1, 0);
        hold(100, 0);
        // Single frame 0x05.
        hold(50, 8'h05);
        // Burst 1..10 overflows the 4-deep FIFO; then drain.
        for (int i = 1; i <= 10; i++) step(1'b0, i);
        hold(260, 10);
        // Reset during data bit 3 of a frame, then a clean 0x80 frame.
        hold(20, 8'h33);
        step(1'b1, 0);
        hold(50, 8'h80);
        // Parity-relevant payloads (odd and even popcount).
        hold(50, 8'h07);
        hold(50, 8'h03);
        // Randomised changes with occasional bursts and resets.
        cur = 8'h03;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                step(1'b1, cur);
            end else begin
                if (r < 18) cur = $urandom_range(0, 255);
                step(1'b0, cur);
            end
        end
        hold(300, cur);
        check("frames_pending", exp_frames.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
